// File: rtl/rom_serializer.sv
// Framed bit-serial transmitter that walks a word ROM: start bit, data LSB first, optional parity, stop bit.
// Define SER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rom_serializer #(
    parameter int WORD_W = 4,
    parameter int ADDR_W = 4,
    parameter int BIT_W  = 2,
    parameter int DIV    = 1
) (
    input  logic              hit,
    input  logic              clr,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [WORD_W-1:0] rom_data,
    output logic [ADDR_W-1:0] NOM,
    output logic [BIT_W-1:0]  BIT,
    output logic [WORD_W-1:0] LE,
    output logic              TX,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             bit_end;

    function automatic logic sel_bit(input logic [WORD_W-1:0] word, input logic [BIT_W-1:0] idx);
        logic [WORD_W-1:0] sh;
        sh = word >> idx;
        return sh[0];
    endfunction

`ifdef SER_PARITY_EN
    function automatic logic even_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction
`endif

    assign bit_end = (div == DIV_LAST);

    // TX is registered, so each transition loads the line level of the state being entered.
    always_ff @(posedge hit or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            NOM   <= '0;
            BIT   <= '0;
            LE    <= '0;
            TX    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            div   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                NOM   <= '0;
                BIT   <= '0;
                TX    <= 1'b1;
                busy  <= 1'b0;
                div   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        TX <= 1'b1;
                        if (start) begin
                            NOM   <= '0;
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        LE    <= rom_data;
                        BIT   <= '0;
                        div   <= '0;
                        TX    <= 1'b0;
                        state <= S_START;
                    end
                    default: begin
                        if (!bit_end) begin
                            div <= div + 1'b1;
                        end else begin
                            div <= '0;
                            case (state)
                                S_START: begin
                                    TX    <= sel_bit(LE, '0);
                                    state <= S_DATA;
                                end
                                S_DATA: begin
                                    if (BIT == LAST_BIT) begin
                                        BIT <= '0;
`ifdef SER_PARITY_EN
                                        TX    <= even_parity(LE);
                                        state <= S_PARITY;
`else
                                        TX    <= 1'b1;
                                        state <= S_STOP;
`endif
                                    end else begin
                                        BIT <= BIT + 1'b1;
                                        TX  <= sel_bit(LE, BIT + 1'b1);
                                    end
                                end
`ifdef SER_PARITY_EN
                                S_PARITY: begin
                                    TX    <= 1'b1;
                                    state <= S_STOP;
                                end
`endif
                                S_STOP: begin
                                    TX <= 1'b1;
                                    if (NOM != '1) begin
                                        NOM   <= NOM + 1'b1;
                                        state <= S_FETCH;
                                    end else if (cont) begin
                                        NOM   <= '0;
                                        state <= S_FETCH;
                                    end else begin
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                        state <= S_IDLE;
                                    end
                                end
                                default: begin
                                    TX    <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_serializer.sv
// Directed bench for rom_serializer: a DIV=1 instance for framing, sweep, wrap, abort and reset,
// and a DIV=3 instance for bit stretching and the word period with or without SER_PARITY_EN.
module tb_rom_serializer;

    logic       hit;
    logic       clr;
    logic       start, cont, abort;
    logic [3:0] rom_data;
    logic [3:0] NOM;
    logic [1:0] BIT;
    logic [3:0] LE;
    logic       TX, busy, done;

    logic       start3, cont3, abort3;
    logic [3:0] rom_data3;
    logic [3:0] NOM3;
    logic [1:0] BIT3;
    logic [3:0] LE3;
    logic       TX3, busy3, done3;

    logic [3:0] rom  [16];
    logic [3:0] rom3 [16];

    int checks = 0;
    int errors = 0;

    rom_serializer #(.WORD_W(4), .ADDR_W(4), .BIT_W(2), .DIV(1)) u_dut (
        .hit(hit), .clr(clr), .start(start), .cont(cont), .abort(abort),
        .rom_data(rom_data), .NOM(NOM), .BIT(BIT), .LE(LE), .TX(TX),
        .busy(busy), .done(done)
    );

    rom_serializer #(.WORD_W(4), .ADDR_W(4), .BIT_W(2), .DIV(3)) u_dut3 (
        .hit(hit), .clr(clr), .start(start3), .cont(cont3), .abort(abort3),
        .rom_data(rom_data3), .NOM(NOM3), .BIT(BIT3), .LE(LE3), .TX(TX3),
        .busy(busy3), .done(done3)
    );

    assign rom_data  = rom[NOM];
    assign rom_data3 = rom3[NOM3];

    initial hit = 1'b0;
    always #5 hit = ~hit;

    task automatic step();
        @(posedge hit);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int done_cnt;
        int nom_ok;
        int busy_ok;
        logic exp_tx;

        for (int i = 0; i < 16; i++) begin
            rom[i]  = 4'(i);
            rom3[i] = 4'(15 - i);
        end
        rom[0]  = 4'b1010;
        rom[1]  = 4'b0000;
        rom[3]  = 4'b0101;
        rom3[0] = 4'b0111;

        clr = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
        start3 = 1'b0; cont3 = 1'b0; abort3 = 1'b0;
        #2 clr = 1'b0;
        #2;
        chk("rst_nom", NOM, 0);
        chk("rst_bit", BIT, 0);
        chk("rst_le", LE, 0);
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #4 clr = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_tx", TX, 1);

        // DIV=3 instance: 3-clock bits, ROM word 0111, parity bit 1 when enabled
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("d3_fetch_busy", busy3, 1);
        for (int n = 1; n <= 18; n++) begin
            step();
            exp_tx = ((n >= 1 && n <= 3) || (n >= 13 && n <= 15)) ? 1'b0 : 1'b1;
            chk($sformatf("d3_tx_n%0d", n), TX3, exp_tx);
            if (n == 7) chk("d3_bit1", BIT3, 1);
        end
        step();
`ifdef SER_PARITY_EN
        chk("d3_nom_n19", NOM3, 0);
`else
        chk("d3_nom_n19", NOM3, 1);
`endif
        repeat (3) step();
        chk("d3_nom_n22", NOM3, 1);
        abort3 = 1'b1;
        step();
        abort3 = 1'b0;
        chk("d3_abort_busy", busy3, 0);

        // Single frame of word 0 then the full 16-word sweep
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fetch_busy", busy, 1);
        chk("fetch_tx", TX, 1);
        step();
        chk("start_tx", TX, 0);
        chk("start_le", LE, 4'b1010);
        step(); chk("d0_tx", TX, 0); chk("d0_bit", BIT, 0);
        step(); chk("d1_tx", TX, 1); chk("d1_bit", BIT, 1);
        step(); chk("d2_tx", TX, 0); chk("d2_bit", BIT, 2);
        step(); chk("d3_tx", TX, 1); chk("d3_bit", BIT, 3);
        step(); chk("stop_tx", TX, 1); chk("stop_bit", BIT, 0);
        step(); chk("w1_nom", NOM, 1);
        done_cnt = 0; nom_ok = 1; busy_ok = 1;
        for (int n = 8; n <= 111; n++) begin
            step();
            done_cnt += int'(done);
            if (!busy) busy_ok = 0;
            if (n % 7 == 0 && int'(NOM) != n / 7) nom_ok = 0;
        end
        chk("sweep_no_early_done", done_cnt, 0);
        chk("sweep_nom_walk", nom_ok, 1);
        chk("sweep_busy_held", busy_ok, 1);
        step();
        chk("sweep_done", done, 1);
        chk("sweep_busy_fall", busy, 0);
        chk("sweep_nom_end", NOM, 15);
        step();
        chk("sweep_done_pulse", done, 0);
        chk("sweep_nom_hold", NOM, 15);

        // Asynchronous reset in the middle of word 1's data bits
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("mid_tx", TX, 0);
        chk("mid_bit", BIT, 1);
        chk("mid_nom", NOM, 1);
        #2 clr = 1'b0;
        #1;
        chk("arst_tx", TX, 1);
        chk("arst_busy", busy, 0);
        chk("arst_nom", NOM, 0);
        chk("arst_bit", BIT, 0);
        #2 clr = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tx", TX, 1);

        // Continuous mode: wrap once, then drop cont during the second pass
        cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 111; n++) begin
            step();
            done_cnt += int'(done);
        end
        step();
        chk("wrap_nom", NOM, 0);
        chk("wrap_busy", busy, 1);
        chk("wrap_no_done", done_cnt + int'(done), 0);
        for (int n = 113; n <= 223; n++) begin
            step();
            if (n == 120) cont = 1'b0;
            done_cnt += int'(done);
        end
        chk("pass2_no_early_done", done_cnt, 0);
        step();
        chk("pass2_done", done, 1);
        chk("pass2_nom", NOM, 15);
        chk("pass2_busy", busy, 0);

        // Ignored start while busy, then abort during word 3's data
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (n == 7) chk("busy_start_ignored", NOM, 1);
        end
        chk("pre_abort_nom", NOM, 3);
        chk("pre_abort_bit", BIT, 1);
        chk("pre_abort_tx", TX, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_tx", TX, 1);
        chk("abort_busy", busy, 0);
        chk("abort_bit", BIT, 0);
        chk("abort_nom", NOM, 0);
        done_cnt = int'(done);
        repeat (3) step() ;
        done_cnt += int'(done);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stays_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
